// File: rtl/pulse_conditioner.sv
// Input conditioning ahead of the decade down-counter: synchronizes btn_in/run_in,
// debounces the button into single-cycle pulses. Define AUTOREPEAT_EN for hold-to-repeat pulses.
module pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic clk,
  input  logic clear,
  input  logic btn_in,
  input  logic run_in,
  output logic pulse_out,
  output logic en_out,
  output logic pressed
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 2..255");
  end
  if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > 255) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CONFIRM_HIGH = 2'd1,
    HELD         = 2'd2,
    CONFIRM_LOW  = 2'd3
  } state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  state_t     state, state_nxt;
  logic       btn_s1, btn_s2, run_s1;
  logic [7:0] cnt, cnt_nxt;
  logic       pulse_nxt, pressed_nxt;

  // en_out is the second synchronizer flop of run_in itself.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      run_s1 <= 1'b0;
      en_out <= 1'b0;
    end else begin
      btn_s1 <= btn_in;
      btn_s2 <= btn_s1;
      run_s1 <= run_in;
      en_out <= run_s1;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      pulse_out <= 1'b0;
      pressed   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pulse_out <= pulse_nxt;
      pressed   <= pressed_nxt;
    end
  end

`ifdef AUTOREPEAT_EN
  localparam logic [7:0] REP_LAST = 8'(REPEAT_CYCLES - 1);
  logic [7:0] rep, rep_nxt;
  logic       rep_fire;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) rep <= 8'd0;
    else       rep <= rep_nxt;
  end

  // The period only runs while the FSM stays in HELD; any exit or re-entry restarts it.
  always_comb begin
    rep_nxt  = 8'd0;
    rep_fire = 1'b0;
    if (state == HELD && state_nxt == HELD) begin
      if (rep == REP_LAST) rep_fire = 1'b1;
      else                 rep_nxt  = rep + 8'd1;
    end
  end
`else
  logic rep_fire;
  assign rep_fire = 1'b0;
`endif

  // Within a CONFIRM state the btn_s2 abort/return branch is tested before the terminal count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s2) begin
          state_nxt = CONFIRM_HIGH;
          cnt_nxt   = 8'd0;
        end
      end
      CONFIRM_HIGH: begin
        if (!btn_s2) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = 8'd0;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      HELD: begin
        if (!btn_s2) begin
          state_nxt = CONFIRM_LOW;
          cnt_nxt   = 8'd0;
        end
      end
      CONFIRM_LOW: begin
        if (btn_s2) begin
          state_nxt = HELD;
          cnt_nxt   = 8'd0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
    if (rep_fire) pulse_nxt = 1'b1;
    pressed_nxt = (state_nxt == HELD) || (state_nxt == CONFIRM_LOW);
  end

endmodule

// File: tb/tb_pulse_conditioner.sv
// Directed bench for pulse_conditioner: expected pulse edges are queued as stimulus is
// driven and popped by a monitor when pulse_out is seen high.
module tb_pulse_conditioner;
  localparam int D = 4;
  localparam int R = 8;

  logic clk = 1'b0;
  logic clear, btn_in, run_in;
  logic pulse_out, en_out, pressed;

  pulse_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .clear(clear), .btn_in(btn_in), .run_in(run_in),
    .pulse_out(pulse_out), .en_out(en_out), .pressed(pressed)
  );

  always #5 clk = ~clk;

  // Rising-edge counter; edge N is the edge that samples inputs set after edge N-1.
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic prev_pulse = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds btn_in high for n cycles then low for gap cycles, queueing the pulses it should cause.
  task automatic press(input int n, input int gap);
    int start;
    start = edge_cnt + 1;
    if (n >= D + 1) begin
      exp_q.push_back(start + D + 2);
`ifdef AUTOREPEAT_EN
      for (int e = start + D + 2 + R; e <= start + n + 1; e += R) exp_q.push_back(e);
`endif
    end
    btn_in = 1'b1;
    wait_cyc(n);
    btn_in = 1'b0;
    wait_cyc(gap);
  endtask

  always @(negedge clk) begin
    if (pulse_out === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_pulse_edge", edge_cnt, 0);
      else                   check("pulse_edge", edge_cnt, exp_q.pop_front());
      check("pressed_during_pulse", pressed, 1);
      check("pulse_not_back_to_back", prev_pulse, 0);
    end
    prev_pulse <= pulse_out;
  end

  initial begin
    int s;
    clear = 1'b1; btn_in = 1'b0; run_in = 1'b0;
    wait_cyc(3);
    check("reset_pulse", pulse_out, 0);
    check("reset_en", en_out, 0);
    check("reset_pressed", pressed, 0);
    clear = 1'b0;
    wait_cyc(20);
    check("idle_pressed", pressed, 0);

    // Clean 20-cycle press with pressed timing around assertion and release.
    s = edge_cnt + 1;
    exp_q.push_back(s + D + 2);
`ifdef AUTOREPEAT_EN
    for (int e = s + D + 2 + R; e <= s + 21; e += R) exp_q.push_back(e);
`endif
    btn_in = 1'b1;
    wait_cyc(D + 2);
    check("pressed_before_pulse", pressed, 0);
    wait_cyc(1);
    check("pressed_at_pulse", pressed, 1);
    wait_cyc(20 - (D + 3));
    btn_in = 1'b0;
    wait_cyc(D + 2);
    check("pressed_late_release", pressed, 1);
    wait_cyc(1);
    check("pressed_after_release", pressed, 0);
    wait_cyc(10);

    // Short highs are rejected; D samples is the longest rejected width.
    for (int i = 0; i < 5; i++) begin
      press(3, 10);
      check("glitch_pressed", pressed, 0);
    end
    press(D, 10);
    check("boundary_short_pressed", pressed, 0);
    press(D + 1, 12);
    check("boundary_min_pressed", pressed, 0);

    // Press bounce, then a 2-cycle low glitch while held.
    btn_in = 1'b1; wait_cyc(1);
    btn_in = 1'b0; wait_cyc(1);
    btn_in = 1'b1; wait_cyc(1);
    btn_in = 1'b0; wait_cyc(1);
    s = edge_cnt + 1;
    exp_q.push_back(s + D + 2);
`ifdef AUTOREPEAT_EN
    for (int e = s + 16 + R; e <= s + 25; e += R) exp_q.push_back(e);
`endif
    btn_in = 1'b1;
    wait_cyc(12);
    btn_in = 1'b0;
    wait_cyc(2);
    btn_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_cyc(1);
      check("pressed_through_glitch", pressed, 1);
    end
    wait_cyc(6);
    btn_in = 1'b0;
    wait_cyc(12);
    check("bounce_released", pressed, 0);

    // run_in passes through with two edges of latency.
    run_in = 1'b1;
    wait_cyc(1); check("en_rise_edge1", en_out, 0);
    wait_cyc(1); check("en_rise_edge2", en_out, 1);
    wait_cyc(8);
    run_in = 1'b0;
    wait_cyc(1); check("en_fall_edge1", en_out, 1);
    wait_cyc(1); check("en_fall_edge2", en_out, 0);
    wait_cyc(8);

    // Clear in the middle of CONFIRM_HIGH discards the press; a fresh window follows.
    run_in = 1'b1;
    btn_in = 1'b1;
    wait_cyc(4);
    clear = 1'b1;
    #1;
    check("clear_en", en_out, 0);
    check("clear_pressed", pressed, 0);
    check("clear_pulse", pulse_out, 0);
    wait_cyc(2);
    clear = 1'b0;
    s = edge_cnt + 1;
    exp_q.push_back(s + D + 2);
    wait_cyc(2);
    check("en_after_clear", en_out, 1);
    wait_cyc(D + 3);
    check("pressed_new_window", pressed, 1);
    wait_cyc(3);
    btn_in = 1'b0;
    wait_cyc(12);
    run_in = 1'b0;

    // Long hold: single pulse, or auto-repeat train when enabled.
    press(40, 12);
    check("long_released", pressed, 0);

    wait_cyc(20);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
